cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 151 +++++++++++++++
 tb/tb_cache_arbiter.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - arbitrates I-cache and D-cache line requests onto one memory adaptor
// One transaction at a time; every output comes straight from a flop.
module cache_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  i_address_i,
    input  logic         i_read_i,
    output logic [255:0] i_rdata_o,
    output logic         i_resp_o,
    input  logic [31:0]  d_address_i,
    input  logic         d_read_i,
    input  logic         d_write_i,
    input  logic [255:0] d_wdata_i,
    output logic [255:0] d_rdata_o,
    output logic         d_resp_o,
    output logic [31:0]  mem_address_o,
    output logic [255:0] mem_line_o,
    input  logic [255:0] mem_line_i,
    output logic         mem_read_o,
    output logic         mem_write_o,
    input  logic         mem_resp_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic [31:0]    mem_address_q, mem_address_d;
    logic [255:0]   mem_line_q, mem_line_d;
    logic           mem_read_q, mem_read_d;
    logic           mem_write_q, mem_write_d;
    logic [255:0]   i_rdata_q, i_rdata_d;
    logic [255:0]   d_rdata_q, d_rdata_d;
    logic           i_resp_q, i_resp_d;
    logic           d_resp_q, d_resp_d;

    logic           d_req;
    logic           grant_d;

    always_comb begin
        d_req   = d_read_i | d_write_i;
        grant_d = d_req;
        if (d_req && i_read_i) begin
            // Tie: round-robin favours whoever did not win last time.
            grant_d = RR_EN ? (last_grant_q == GRANT_I) : 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        mem_address_d = mem_address_q;
        mem_line_d    = mem_line_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        i_rdata_d     = i_rdata_q;
        d_rdata_d     = d_rdata_q;
        i_resp_d      = 1'b0;
        d_resp_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d       = SERVE_D;
                    last_grant_d  = GRANT_D;
                    mem_address_d = d_address_i;
                    mem_line_d    = d_wdata_i;
                    // A simultaneous read+write is treated as a writeback.
                    mem_write_d   = d_write_i;
                    mem_read_d    = ~d_write_i;
                end else if (i_read_i) begin
                    state_d       = SERVE_I;
                    last_grant_d  = GRANT_I;
                    mem_address_d = i_address_i;
                    mem_read_d    = 1'b1;
                end
            end
            SERVE_I: begin
                if (mem_resp_i) begin
                    state_d    = DONE;
                    mem_read_d = 1'b0;
                    i_rdata_d  = mem_line_i;
                    i_resp_d   = 1'b1;
                end
            end
            SERVE_D: begin
                if (mem_resp_i) begin
                    state_d     = DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read_q) begin
                        d_rdata_d = mem_line_i;
                    end
                    d_resp_d    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_I;
            mem_address_q <= '0;
            mem_line_q    <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            i_resp_q      <= 1'b0;
            d_resp_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            mem_address_q <= mem_address_d;
            mem_line_q    <= mem_line_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            i_rdata_q     <= i_rdata_d;
            d_rdata_q     <= d_rdata_d;
            i_resp_q      <= i_resp_d;
            d_resp_q      <= d_resp_d;
        end
    end

    assign i_rdata_o     = i_rdata_q;
    assign i_resp_o      = i_resp_q;
    assign d_rdata_o     = d_rdata_q;
    assign d_resp_o      = d_resp_q;
    assign mem_address_o = mem_address_q;
    assign mem_line_o    = mem_line_q;
    assign mem_read_o    = mem_read_q;
    assign mem_write_o   = mem_write_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter
// DUT a uses round-robin ties, DUT b always favours the D-cache.
module tb_cache_arbiter;

    localparam int LAT     = 4;
    localparam int TIMEOUT = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic [31:0]  i_address, d_address;
    logic         i_read, d_read, d_write;
    logic [255:0] d_wdata, rd_line;
    logic         idle_pulse;

    logic [255:0] a_i_rdata, a_d_rdata, a_mem_line;
    logic         a_i_resp, a_d_resp, a_mem_read, a_mem_write;
    logic [31:0]  a_mem_address;
    logic         resp_a_q, mem_resp_a;
    int           cnt_a;

    logic         b_i_read, b_d_read, b_d_write;
    logic [255:0] b_i_rdata, b_d_rdata, b_mem_line;
    logic         b_i_resp, b_d_resp, b_mem_read, b_mem_write;
    logic [31:0]  b_mem_address;
    logic         resp_b_q;
    int           cnt_b;

    assign mem_resp_a = resp_a_q | idle_pulse;

    cache_arbiter #(.RR_EN(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .i_address_i(i_address), .i_read_i(i_read),
        .i_rdata_o(a_i_rdata), .i_resp_o(a_i_resp),
        .d_address_i(d_address), .d_read_i(d_read), .d_write_i(d_write),
        .d_wdata_i(d_wdata), .d_rdata_o(a_d_rdata), .d_resp_o(a_d_resp),
        .mem_address_o(a_mem_address), .mem_line_o(a_mem_line),
        .mem_line_i(rd_line), .mem_read_o(a_mem_read), .mem_write_o(a_mem_write),
        .mem_resp_i(mem_resp_a)
    );

    cache_arbiter #(.RR_EN(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .i_address_i(i_address), .i_read_i(b_i_read),
        .i_rdata_o(b_i_rdata), .i_resp_o(b_i_resp),
        .d_address_i(d_address), .d_read_i(b_d_read), .d_write_i(b_d_write),
        .d_wdata_i(d_wdata), .d_rdata_o(b_d_rdata), .d_resp_o(b_d_resp),
        .mem_address_o(b_mem_address), .mem_line_o(b_mem_line),
        .mem_line_i(rd_line), .mem_read_o(b_mem_read), .mem_write_o(b_mem_write),
        .mem_resp_i(resp_b_q)
    );

    // Adaptor models: answer each strobe with a one-cycle pulse after LAT cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_a    <= 0;
            resp_a_q <= 1'b0;
        end else begin
            resp_a_q <= 1'b0;
            if ((a_mem_read || a_mem_write) && !resp_a_q) begin
                if (cnt_a == LAT - 1) begin
                    resp_a_q <= 1'b1;
                    cnt_a    <= 0;
                end else begin
                    cnt_a <= cnt_a + 1;
                end
            end
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_b    <= 0;
            resp_b_q <= 1'b0;
        end else begin
            resp_b_q <= 1'b0;
            if ((b_mem_read || b_mem_write) && !resp_b_q) begin
                if (cnt_b == LAT - 1) begin
                    resp_b_q <= 1'b1;
                    cnt_b    <= 0;
                end else begin
                    cnt_b <= cnt_b + 1;
                end
            end
        end
    end

    typedef struct {
        logic [31:0]  addr;
        bit           wr;
        logic [255:0] line;
    } mem_exp_t;

    typedef struct {
        bit           is_d;
        logic [255:0] data;
    } resp_exp_t;

    mem_exp_t     mem_q[$];
    resp_exp_t    resp_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [255:0] exp_i, exp_d;
    bit           saw_mem_read;
    bit           prev_strobe = 1'b0;
    logic [31:0]  cur_addr;
    bit           cur_wr;

    // Scoreboard monitor for DUT a.
    always @(negedge clk) begin
        mem_exp_t  m;
        resp_exp_t r;
        bit        strobe;
        strobe = a_mem_read || a_mem_write;
        if (!reset_n) begin
            prev_strobe = 1'b0;
        end else begin
            if (strobe && !prev_strobe) begin
                total++;
                if (mem_q.size() == 0) begin
                    bad++;
                    $display("FAIL mem_unexpected: addr=%h rd=%b wr=%b, no transaction expected",
                             a_mem_address, a_mem_read, a_mem_write);
                end else begin
                    m = mem_q.pop_front();
                    if (a_mem_address !== m.addr || a_mem_write !== m.wr ||
                        a_mem_read !== !m.wr || (m.wr && a_mem_line !== m.line)) begin
                        bad++;
                        $display("FAIL mem_txn: addr=%h rd=%b wr=%b line=%h want addr=%h wr=%b line=%h",
                                 a_mem_address, a_mem_read, a_mem_write, a_mem_line, m.addr, m.wr, m.line);
                    end
                end
                cur_addr = a_mem_address;
                cur_wr   = a_mem_write;
            end else if (strobe) begin
                total++;
                if (a_mem_address !== cur_addr || a_mem_write !== cur_wr || a_mem_read !== !cur_wr) begin
                    bad++;
                    $display("FAIL mem_stable: addr=%h wr=%b rd=%b want addr=%h wr=%b",
                             a_mem_address, a_mem_write, a_mem_read, cur_addr, cur_wr);
                end
            end
            prev_strobe = strobe;

            if (a_i_resp || a_d_resp) begin
                total++;
                if (a_i_resp && a_d_resp) begin
                    bad++;
                    $display("FAIL resp_exclusive: i_resp=1 d_resp=1 want at most one");
                end else if (resp_q.size() == 0) begin
                    bad++;
                    $display("FAIL resp_unexpected: i_resp=%b d_resp=%b want none", a_i_resp, a_d_resp);
                end else begin
                    r = resp_q.pop_front();
                    if (a_d_resp !== r.is_d) begin
                        bad++;
                        $display("FAIL resp_client: d_resp=%b want %b", a_d_resp, r.is_d);
                    end else if (r.is_d && a_d_rdata !== r.data) begin
                        bad++;
                        $display("FAIL d_rdata: got %h want %h", a_d_rdata, r.data);
                    end else if (!r.is_d && a_i_rdata !== r.data) begin
                        bad++;
                        $display("FAIL i_rdata: got %h want %h", a_i_rdata, r.data);
                    end
                end
            end
        end
    end

    task automatic wait_a_resp(output bit got_d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            if (a_mem_read) saw_mem_read = 1'b1;
            n++;
        end while (!(a_i_resp || a_d_resp) && n < TIMEOUT);
        total++;
        if (!(a_i_resp || a_d_resp)) begin
            bad++;
            $display("FAIL resp_timeout: no resp after %0d cycles", n);
        end
        got_d = a_d_resp;
    endtask

    task automatic do_txn(input bit i_rd, input bit d_rd, input bit d_wr, input logic [31:0] addr,
                          input logic [255:0] wline, input logic [255:0] rline, output bit got_d);
        bit is_d;
        is_d = d_rd || d_wr;
        mem_q.push_back('{addr: addr, wr: is_d && d_wr, line: wline});
        if (is_d) begin
            if (!d_wr) exp_d = rline;
            resp_q.push_back('{is_d: 1'b1, data: exp_d});
            d_address = addr;
            d_wdata   = wline;
            d_read    = d_rd;
            d_write   = d_wr;
        end else begin
            exp_i = rline;
            resp_q.push_back('{is_d: 1'b0, data: exp_i});
            i_address = addr;
            i_read    = i_rd;
        end
        rd_line      = rline;
        saw_mem_read = 1'b0;
        wait_a_resp(got_d);
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        b_i_read = 1'b0; b_d_read = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        exp_i = '0;
        exp_d = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({a_i_resp, a_d_resp, a_mem_read, a_mem_write} !== 4'b0 || a_mem_address !== 32'h0) begin
            bad++;
            $display("FAIL reset_a_ctrl: resp/strobe=%b addr=%h want 0", {a_i_resp, a_d_resp, a_mem_read, a_mem_write}, a_mem_address);
        end
        total++;
        if (a_mem_line !== '0 || a_i_rdata !== '0 || a_d_rdata !== '0) begin
            bad++;
            $display("FAIL reset_a_data: line=%h i=%h d=%h want 0", a_mem_line, a_i_rdata, a_d_rdata);
        end
        total++;
        if ({b_i_resp, b_d_resp, b_mem_read, b_mem_write} !== 4'b0 || b_mem_address !== 32'h0 ||
            b_mem_line !== '0 || b_i_rdata !== '0 || b_d_rdata !== '0) begin
            bad++;
            $display("FAIL reset_b: resp/strobe=%b addr=%h want all 0", {b_i_resp, b_d_resp, b_mem_read, b_mem_write}, b_mem_address);
        end
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_i_read();
        bit got_d;
        int extra;
        logic [255:0] aa;
        aa = {8{32'hAAAA_AAAA}};
        exp_i = aa;
        mem_q.push_back('{addr: 32'h0000_1000, wr: 1'b0, line: '0});
        resp_q.push_back('{is_d: 1'b0, data: aa});
        rd_line   = aa;
        i_address = 32'h0000_1000;
        i_read    = 1'b1;
        @(negedge clk);
        total++;
        if (a_mem_read !== 1'b1 || a_mem_address !== 32'h0000_1000) begin
            bad++;
            $display("FAIL i_latency: mem_read=%b addr=%h want 1 00001000", a_mem_read, a_mem_address);
        end
        wait_a_resp(got_d);
        i_read = 1'b0;
        total++;
        if (got_d || a_i_rdata !== aa) begin
            bad++;
            $display("FAIL i_read_data: d=%b i_rdata=%h want %h", got_d, a_i_rdata, aa);
        end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_i_resp) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL i_single_pulse: extra pulses=%0d want 0", extra);
        end
    endtask

    task automatic test_d_read();
        bit got_d;
        do_txn(1'b0, 1'b1, 1'b0, 32'h0000_2400, '0, {8{32'h1234_5678}}, got_d);
        total++;
        if (!got_d || a_d_rdata !== {8{32'h1234_5678}} || a_i_rdata !== {8{32'hAAAA_AAAA}}) begin
            bad++;
            $display("FAIL d_read: d=%b d_rdata=%h i_rdata=%h", got_d, a_d_rdata, a_i_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_d_write();
        bit got_d;
        do_txn(1'b0, 1'b0, 1'b1, 32'h0000_2000, {8{32'h5555_5555}}, {8{32'hDEAD_BEEF}}, got_d);
        total++;
        if (!got_d || a_d_rdata !== {8{32'h1234_5678}}) begin
            bad++;
            $display("FAIL d_write_rdata: d=%b d_rdata=%h want unchanged %h", got_d, a_d_rdata, {8{32'h1234_5678}});
        end
        @(negedge clk);
    endtask

    task automatic test_both_high();
        bit got_d;
        do_txn(1'b0, 1'b1, 1'b1, 32'h0000_2800, {8{32'h0F0F_3C3C}}, {8{32'h7777_7777}}, got_d);
        total++;
        if (!got_d || saw_mem_read || a_d_rdata !== {8{32'h1234_5678}}) begin
            bad++;
            $display("FAIL both_high: d=%b saw_read=%b d_rdata=%h want write only", got_d, saw_mem_read, a_d_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_tie_rr();
        bit got_d, want_d;
        logic [255:0] rline;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            want_d    = (r != 1);
            rline     = {8{32'h0D0D_0000 + 32'(r)}};
            i_address = 32'h0000_3000 + 32'(r * 64);
            d_address = 32'h0000_4000 + 32'(r * 64);
            d_wdata   = '0;
            rd_line   = rline;
            if (want_d) begin
                exp_d = rline;
                mem_q.push_back('{addr: d_address, wr: 1'b0, line: '0});
                resp_q.push_back('{is_d: 1'b1, data: rline});
            end else begin
                exp_i = rline;
                mem_q.push_back('{addr: i_address, wr: 1'b0, line: '0});
                resp_q.push_back('{is_d: 1'b0, data: rline});
            end
            i_read = 1'b1;
            d_read = 1'b1;
            wait_a_resp(got_d);
            i_read = 1'b0;
            d_read = 1'b0;
            total++;
            if (got_d !== want_d) begin
                bad++;
                $display("FAIL tie_rr_round%0d: granted_d=%b want %b", r, got_d, want_d);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_tie_rr0();
        int n;
        for (int r = 0; r < 3; r++) begin
            rd_line   = {8{32'hB0B0_0000 + 32'(r)}};
            i_address = 32'h0000_5000;
            d_address = 32'h0000_6000 + 32'(r * 64);
            b_i_read  = 1'b1;
            b_d_read  = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(b_i_resp || b_d_resp) && n < TIMEOUT);
            b_i_read = 1'b0;
            b_d_read = 1'b0;
            total++;
            if (b_d_resp !== 1'b1 || b_i_resp !== 1'b0 || b_d_rdata !== rd_line) begin
                bad++;
                $display("FAIL tie_rr0_round%0d: d_resp=%b i_resp=%b d_rdata=%h want D with %h",
                         r, b_d_resp, b_i_resp, b_d_rdata, rd_line);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bit got_d;
        int pulses;
        mem_q.push_back('{addr: 32'h0000_5000, wr: 1'b0, line: '0});
        rd_line   = {8{32'h9999_9999}};
        i_address = 32'h0000_5000;
        i_read    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (a_mem_read !== 1'b0 || a_i_resp !== 1'b0 || a_mem_address !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid: mem_read=%b i_resp=%b addr=%h want 0", a_mem_read, a_i_resp, a_mem_address);
        end
        i_read = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        exp_i = '0;
        exp_d = '0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_i_resp || a_mem_read) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL reset_mid_quiet: activity cycles=%0d want 0", pulses);
        end
        do_txn(1'b1, 1'b0, 1'b0, 32'h0000_6000, '0, {8{32'h6666_6666}}, got_d);
        total++;
        if (got_d || a_i_rdata !== {8{32'h6666_6666}}) begin
            bad++;
            $display("FAIL reset_mid_next: d=%b i_rdata=%h want %h", got_d, a_i_rdata, {8{32'h6666_6666}});
        end
        @(negedge clk);
    endtask

    task automatic test_idle_resp();
        bit got_d;
        int act;
        @(negedge clk);
        idle_pulse = 1'b1;
        @(negedge clk);
        idle_pulse = 1'b0;
        act = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_i_resp || a_d_resp || a_mem_read || a_mem_write) act++;
        end
        total++;
        if (act != 0 || a_i_rdata !== {8{32'h6666_6666}}) begin
            bad++;
            $display("FAIL idle_resp: activity=%0d i_rdata=%h want 0 and unchanged", act, a_i_rdata);
        end
        do_txn(1'b0, 1'b1, 1'b0, 32'h0000_7000, '0, {8{32'hC3C3_C3C3}}, got_d);
        total++;
        if (!got_d || a_d_rdata !== {8{32'hC3C3_C3C3}}) begin
            bad++;
            $display("FAIL idle_resp_next: d=%b d_rdata=%h", got_d, a_d_rdata);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        i_address  = '0;
        d_address  = '0;
        i_read     = 1'b0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_wdata    = '0;
        rd_line    = '0;
        idle_pulse = 1'b0;
        b_i_read   = 1'b0;
        b_d_read   = 1'b0;
        b_d_write  = 1'b0;
        exp_i      = '0;
        exp_d      = '0;

        test_reset();
        test_i_read();
        test_d_read();
        test_d_write();
        test_both_high();
        test_tie_rr();
        test_tie_rr0();
        test_reset_mid();
        test_idle_resp();

        total++;
        if (mem_q.size() != 0 || resp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: mem_q=%0d resp_q=%0d want 0 0", mem_q.size(), resp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
